// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: GF(2^8) arithmetic, S-boxes, Rcon and state indexing.
// S-boxes are derived arithmetically (inverse in GF(2^8) plus affine map) rather than tabulated.
package aes_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Rcon[1..10]; out-of-range indices yield zero
    function automatic logic [7:0] rcon(input logic [3:0] i);
        if (i == 4'd0 || i > 4'd10) return 8'h00;
        return RCON_TABLE[8 * (10 - int'(i)) +: 8];
    endfunction

    function automatic int bidx(input int r, input int c);
        return 4 * c + r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int idx);
        return s[127 - 8 * idx -: 8];
    endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One AES-128 inverse round plus one inverse key-schedule step, purely combinational.
// rnd_i is the round being produced; InvMixColumns is bypassed for round 0.
module aes_inv_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic [3:0]   rnd_i,
    output logic [127:0] next_st_o,
    output logic [127:0] next_rk_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] rot;
    logic [7:0]  sub [16];

    assign w0  = rk_i[127:96];
    assign w1  = rk_i[95:64];
    assign w2  = rk_i[63:32];
    assign w3  = rk_i[31:0];
    assign n3  = w3 ^ w2;
    assign n2  = w2 ^ w1;
    assign n1  = w1 ^ w0;
    assign rot = {n3[23:0], n3[31:24]};
    assign n0  = w0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                    ^ {rcon(4'(rnd_i + 4'd1)), 24'h000000};

    assign next_rk_o = {n0, n1, n2, n3};

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub[bidx(r, c)] = inv_sbox(get_byte(st_i, bidx(r, (c - r + 4) % 4)))
                                  ^ get_byte(next_rk_o, bidx(r, c));
            end
        end
    end

    always_comb begin
        next_st_o = '0;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            a0 = sub[4 * c];
            a1 = sub[4 * c + 1];
            a2 = sub[4 * c + 2];
            a3 = sub[4 * c + 3];
            if (rnd_i == 4'd0) begin
                next_st_o[127 - 32 * c -: 32] = {a0, a1, a2, a3};
            end else begin
                next_st_o[127 - 32 * c -: 32] = {
                    gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                    gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                    gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                    gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
                };
            end
        end
    end

endmodule

// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryption: one inverse round per clock, started from the round-10 key.
// Eleven cycles from accept to the valid_out pulse; ready is high only while idle.
module aes_decrypt_iterative
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    output logic         ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic         valid_out
);

    generate
        if (NR != 10) begin : g_bad_nr
            $error("aes_decrypt_iterative supports only NR=10");
        end
    endgenerate

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] data_out_q, data_out_d;
    logic         valid_out_q, valid_out_d;
    logic [127:0] round_st, round_rk;

    aes_inv_round_comb u_round (
        .st_i      (st_q),
        .rk_i      (rk_q),
        .rnd_i     (rnd_q),
        .next_st_o (round_st),
        .next_rk_o (round_rk)
    );

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        rk_d        = rk_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    st_d    = data_in ^ key_in;
                    rk_d    = key_in;
                    rnd_d   = 4'(NR - 1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                st_d = round_st;
                rk_d = round_rk;
                if (rnd_q == 4'd0) begin
                    data_out_d  = round_st;
                    valid_out_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers; reset also wins over a same-cycle valid_in
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rnd_q       <= 4'd0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        st_q <= st_d;
        rk_q <= rk_d;
    end

    assign ready     = (state_q == ST_IDLE);
    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Directed bench for aes_decrypt_iterative: FIPS-197 vectors, handshake corner cases,
// and a round-trip against an independent forward AES-128 model.
module tb_aes_decrypt_iterative;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic         ready;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic         valid_out;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb [256];

    aes_decrypt_iterative #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready     (ready),
        .data_in   (data_in),
        .key_in    (key_in),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward S-box from the generator-3 walk over GF(2^8)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic aes_enc(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4 * c + r] = sb[s[4 * ((c + r) % 4) + r]];
            for (int c = 0; c < 4; c++) begin
                logic [7:0] a0, a1, a2, a3;
                a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
                if (rd < 10) begin
                    t[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4 * rd + i / 4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = s[i];
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    // Called on a negedge while idle; returns on the negedge where valid_out is seen
    task automatic do_block(input string tag, input logic [127:0] ct, input logic [127:0] key,
                            input logic [127:0] exp, input logic [127:0] hold);
        int lat;
        chk1({tag, "_ready_at_accept"}, ready, 1'b1);
        data_in  = ct;
        key_in   = key;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk1({tag, "_busy"}, ready, 1'b0);
        chk1({tag, "_no_early_valid"}, valid_out, 1'b0);
        chk128({tag, "_hold_prev"}, data_out, hold);
        lat = 1;
        while (!valid_out && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chkint({tag, "_latency"}, lat, 11);
        chk128({tag, "_data"}, data_out, exp);
        chk1({tag, "_ready_with_valid"}, ready, 1'b1);
    endtask

    initial begin
        logic [127:0] m_ct, m_k10, pt, key, prev;
        int npulse, first;

        build_sbox();
        rst      = 1'b1;
        valid_in = 1'b1;
        data_in  = C1_CT;
        key_in   = C1_K10;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        chk1("reset_ready", ready, 1'b1);
        chk1("reset_valid_out", valid_out, 1'b0);
        chk128("reset_data_out", data_out, 128'h0);
        @(negedge clk);
        chk1("reset_nothing_accepted", ready, 1'b1);

        aes_enc(C1_PT, C1_K0, m_ct, m_k10);
        chk128("model_c1_ct", m_ct, C1_CT);
        chk128("model_c1_k10", m_k10, C1_K10);

        do_block("c1", C1_CT, C1_K10, C1_PT, 128'h0);
        do_block("b2b_appb", B_CT, B_K10, B_PT, C1_PT);
        do_block("c1_again", C1_CT, C1_K10, C1_PT, B_PT);

        @(negedge clk);
        data_in  = C1_CT;
        key_in   = C1_K10;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        npulse   = 0;
        first    = 0;
        for (int k = 1; k <= 25; k++) begin
            if (valid_out) begin
                npulse++;
                if (first == 0) first = k;
            end
            if (k <= 10) chk1("busydrop_ready_low", ready, 1'b0);
            if (k == 3 || k == 4 || k == 7) begin
                valid_in = 1'b1;
                data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
                key_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
        end
        chkint("busydrop_first_valid", first, 11);
        chkint("busydrop_pulse_count", npulse, 1);
        chk128("busydrop_data", data_out, C1_PT);

        data_in  = C1_CT;
        key_in   = C1_K10;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("midrst_ready", ready, 1'b1);
        chk128("midrst_data_cleared", data_out, 128'h0);
        chk1("midrst_valid_out", valid_out, 1'b0);
        npulse = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (valid_out) npulse++;
        end
        chkint("midrst_no_valid", npulse, 0);
        do_block("midrst_fresh_c1", C1_CT, C1_K10, C1_PT, 128'h0);

        prev = C1_PT;
        for (int n = 0; n < 100; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            aes_enc(pt, key, m_ct, m_k10);
            do_block("roundtrip", m_ct, m_k10, pt, prev);
            prev = pt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_iterative.md
Name: aes_decrypt_iterative

Overview:
- Iterative AES-128 decryption core, the inverse of the encryption datapath that ends in the final round.
- Accepts a 128-bit ciphertext block together with the last (round-10) round key.
- Derives earlier round keys on the fly with the inverse key schedule and performs one inverse round per clock.
- Returns the plaintext with a valid/ready handshake; this is the receive-side block that pairs with the encryption pipeline.

Parameters:
- NR, 10, number of cipher rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in/key_in valid this cycle.
- ready  output  1  core can accept a block; high only in IDLE.
- data_in  input  128  ciphertext. Byte 0 = [127:120], column-major state per FIPS-197.
- key_in  input  128  round-10 round key, same byte order.
- data_out  output  128  plaintext; held until the next result or reset.
- valid_out  output  1  one-cycle pulse when data_out is updated.

Behaviour:
- Reset (sync, active-high):
  - On any rising edge with rst=1: FSM <= IDLE, round counter <= 0, valid_out <= 0, data_out <= 0.
  - ready reads 1 from the first cycle after reset.
  - valid_in is ignored in any cycle where rst=1.
- FSM states: IDLE, RUN.
- IDLE:
  - ready=1.
  - Accept when valid_in=1.
  - On accept: st <= data_in ^ key_in (AddRoundKey k10), rk <= key_in, rnd <= 9, go to RUN.
- RUN (ready=0): each cycle computes round rnd combinationally.
  - Key step (rk = k[rnd+1] -> k[rnd]), words w0..w3 with w0 = [127:96]:
    - w3' = w3^w2
    - w2' = w2^w1
    - w1' = w1^w0
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon[rnd+1], with Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the top byte.
  - Data step: InvShiftRows -> InvSubBytes -> AddRoundKey(k[rnd]) -> InvMixColumns.
  - InvMixColumns is skipped when rnd=0.
  - st <= result, rk <= k[rnd].
  - If rnd=0: data_out <= result, valid_out <= 1 for exactly one cycle, go to IDLE.
  - Otherwise rnd <= rnd-1.
- Latency and throughput:
  - Accept on edge T; valid_out is high in the cycle after edge T+10 (11 cycles accept-to-result).
  - ready returns to 1 in that same cycle, so the next block can be accepted while valid_out=1.
  - Throughput: one block per 11 cycles.
- Boundary conditions:
  - valid_in while busy is ignored; the source must hold its data until ready=1.
  - No back-pressure on the output: the consumer must capture data_out on the valid_out pulse.
  - rst asserted mid-RUN aborts the block: no valid_out, and data_out is cleared to 0.
  - rst and valid_in high together: reset wins, nothing is accepted.
- All GF(2^8) arithmetic uses modulus 0x11b. InvMixColumns coefficients are 0e, 0b, 0d, 09.

Decomposition:
- Package aes_pkg holds:
  - forward S-box function (used by the key schedule) and inverse S-box function;
  - Rcon table;
  - xtime and gf_mul functions;
  - state byte/word index helpers;
  - FSM state enum.
- Sub-module aes_inv_round_comb: purely combinational; inputs st, rk, rnd; outputs next_st, next_rk. The top level keeps only the FSM and registers.

Test Plan:
- FIPS-197 C.1:
  - Stimulus: data_in=69c4e0d86a7b0430d8cdb78070b4c55a, key_in=13111d7fe3944a17f307a78b4d2b30c5.
  - Required: data_out=00112233445566778899aabbccddeeff, valid_out exactly 11 cycles after accept.
- FIPS-197 App. B:
  - Stimulus: data_in=3925841d02dc09fbdc118597196a0b32, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: data_out=3243f6a8885a308d313198a2e0370734.
- Back-to-back:
  - Stimulus: present vector B in the cycle valid_out fires for vector C.1.
  - Required: B is accepted there, its result arrives 11 cycles later, data_out holds the C.1 result in between.
- Busy-drop:
  - Stimulus: pulse valid_in with garbage during RUN.
  - Required: ready=0 throughout, result unchanged, exactly one valid_out per accepted block.
- Mid-run reset:
  - Stimulus: assert rst for 1 cycle at round 5.
  - Required: valid_out never fires, data_out=0, ready=1 next cycle, and a fresh C.1 run then decrypts correctly.
- Round-trip:
  - Stimulus: 100 random key/plaintext pairs through the team's encryption model; feed the ciphertext and the model's round-10 key.
  - Required: every recovered plaintext matches the original.
